pin_event_monitor: RTL and testbench

//  Consumes one AVR port pin driven by a core on an unrelated clock, e.g. the shared wired line on
//  PA0/PA2, or the out/mirror/driver_enabled/logic_level pins. Synchronises and debounces the pin.

---
 rtl/pin_event_monitor_pkg.sv | 25 ++
 rtl/pin_evt_fifo.sv | 54 +++++
 rtl/pin_event_monitor.sv | 109 ++++++++++
 tb/tb_pin_event_monitor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_event_monitor_pkg.sv
// Shared definitions for the pin event monitor: parameter defaults, event
// record layout helpers and fixed output widths.
package pin_event_monitor_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE    = 1;
  localparam int unsigned DEF_TS_WIDTH    = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam bit          DEF_RESET_LEVEL = 1'b1;

  // edge_count is a fixed 16-bit wrapping counter
  localparam int unsigned EDGE_CNT_W = 16;

  // Event record is {rise, delta}: delta occupies [ts_w-1:0], rise sits at bit ts_w
  localparam int unsigned DELTA_LSB = 0;

  function automatic int unsigned evt_w(input int unsigned ts_w);
    return ts_w + 1;
  endfunction

  function automatic int unsigned rise_bit(input int unsigned ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/pin_evt_fifo.sv
// Synchronous event FIFO with registered pointers and occupancy count.
// Ports: clk, rst (async active-high), push/wdata write, pop read,
//        rdata shows the head entry, full/empty flags, level = entries queued.
// A push while full is only taken when a pop happens in the same cycle.
module pin_evt_fifo
  import pin_event_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || pop);
  assign rdata     = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
    end
  end

endmodule

// File: rtl/pin_event_monitor.sv
// Pin event monitor: synchronises and debounces one asynchronous pin,
// timestamps each accepted edge with the interval since the previous one
// and queues {rise, delta} events for a consumer.
// Ports: clk/rst (async active-high); en gates event queuing; pin_in raw pin;
//        clr_ovf clears the sticky overflow; evt_valid/evt_ready/evt_rise/
//        evt_delta present the FIFO head; level is the debounced pin level;
//        edge_count counts queued-or-dropped edges; fifo_level is occupancy.
module pin_event_monitor
  import pin_event_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned TS_WIDTH    = DEF_TS_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter bit          RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          pin_in,
  input  logic                          clr_ovf,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_rise,
  output logic [TS_WIDTH-1:0]           evt_delta,
  output logic                          level,
  output logic [EDGE_CNT_W-1:0]         edge_count,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned EVT_W = evt_w(TS_WIDTH);
  localparam int unsigned R_BIT = rise_bit(TS_WIDTH);
  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [TS_WIDTH-1:0]    interval;
  logic                   s_c;
  logic                   accept_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   drop_c;
  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  logic [EVT_W-1:0]       head_c;
  logic [EVT_W-1:0]       wdata_c;

  assign s_c      = sync[SYNC_STAGES-1];
  assign accept_c = (s_c != level) && (cnt == CNT_W'(DEBOUNCE - 1));
  assign push_c   = accept_c && en;
  assign pop_c    = evt_valid && evt_ready;
  // An event is lost only when the FIFO is full and nothing leaves this cycle
  assign drop_c   = push_c && fifo_full_c && !evt_ready;

  assign wdata_c   = {s_c, interval};
  assign evt_valid = !fifo_empty_c;
  assign evt_rise  = head_c[R_BIT];
  assign evt_delta = head_c[DELTA_LSB +: TS_WIDTH];

  // Synchroniser, debounce, interval timer, edge counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= {SYNC_STAGES{RESET_LEVEL}};
      level      <= RESET_LEVEL;
      cnt        <= '0;
      interval   <= '0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin_in};

      if (accept_c) begin
        level <= s_c;
        cnt   <= '0;
      end else if (s_c != level) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      // Interval restarts at 1 on an accepted edge and saturates instead of wrapping
      if (accept_c) interval <= TS_WIDTH'(1);
      else if (interval != {TS_WIDTH{1'b1}}) interval <= interval + TS_WIDTH'(1);

      if (push_c) edge_count <= edge_count + EDGE_CNT_W'(1);

      // A drop in the same cycle as clr_ovf keeps overflow set
      if (drop_c) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  pin_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wdata_c),
    .rdata (head_c),
    .full  (fifo_full_c),
    .empty (fifo_empty_c),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_pin_event_monitor.sv
// Scoreboard bench: stimulus pushes expected events, monitors pop and compare
// on every handshake. A second instance uses DEBOUNCE=3 on its own pin.
module tb_pin_event_monitor;

  typedef struct packed {
    logic        rise;
    logic [15:0] delta;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        pin = 1'b1;
  logic        pin3 = 1'b1;
  logic        clr_ovf = 1'b0;
  logic        ready = 1'b0;
  logic        ready3 = 1'b1;

  logic        evt_valid, evt_rise, level, overflow;
  logic [15:0] evt_delta, edge_count;
  logic [3:0]  fifo_level;
  logic        evt_valid3, evt_rise3, level3, overflow3;
  logic [15:0] evt_delta3, edge_count3;
  logic [3:0]  fifo_level3;

  evt_t exp_q[$];
  evt_t exp3_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pin_event_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .pin_in(pin), .clr_ovf(clr_ovf),
    .evt_valid(evt_valid), .evt_ready(ready), .evt_rise(evt_rise),
    .evt_delta(evt_delta), .level(level), .edge_count(edge_count),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  pin_event_monitor #(.DEBOUNCE(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .pin_in(pin3), .clr_ovf(clr_ovf),
    .evt_valid(evt_valid3), .evt_ready(ready3), .evt_rise(evt_rise3),
    .evt_delta(evt_delta3), .level(level3), .edge_count(edge_count3),
    .overflow(overflow3), .fifo_level(fifo_level3)
  );

  // Monitors: sample 2 time units after the falling edge, when inputs and outputs are settled
  always begin
    @(negedge clk);
    #2;
    if (!rst && evt_valid && ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_evt: got rise=%0b delta=%0d, none expected", evt_rise, evt_delta);
      end else begin
        if ({evt_rise, evt_delta} !== exp_q[0]) begin
          n_err++;
          $display("FAIL evt: got rise=%0b delta=%0d, want rise=%0b delta=%0d",
                   evt_rise, evt_delta, exp_q[0].rise, exp_q[0].delta);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst && evt_valid3 && ready3) begin
      n_vec++;
      if (exp3_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_evt3: got rise=%0b delta=%0d, none expected", evt_rise3, evt_delta3);
      end else begin
        if ({evt_rise3, evt_delta3} !== exp3_q[0]) begin
          n_err++;
          $display("FAIL evt3: got rise=%0b delta=%0d, want rise=%0b delta=%0d",
                   evt_rise3, evt_delta3, exp3_q[0].rise, exp3_q[0].delta);
        end
        void'(exp3_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Release lands on a falling edge, so the next rising edge is edge 1
  task automatic reset_dut();
    rst = 1'b1; en = 1'b1; clr_ovf = 1'b0; pin = 1'b1; pin3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("drain_left", 32'(exp_q.size() + exp3_q.size()), 32'd0);
  endtask

  // Toggle pin n times, first after edge `first`, then every 4 edges; queue the first nq
  task automatic toggles(input int n, input int first, input int nq);
    for (int i = 0; i < n; i++) begin
      repeat ((i == 0) ? first : 4) @(posedge clk);
      @(negedge clk);
      pin = ~pin;
      if (i < nq) exp_q.push_back({pin, (i == 0) ? 16'(first + 2) : 16'd4});
    end
  endtask

  initial begin
    // 1: idle after reset
    reset_dut();
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("t1_valid", 32'(evt_valid), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    check("t1_edge_count", 32'(edge_count), 32'd0);
    check("t1_fifo_level", 32'(fifo_level), 32'd0);
    check("t1_overflow", 32'(overflow), 32'd0);

    // 2: fall after edge 20, rise after edge 30, consumer always ready
    reset_dut();
    ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    pin = 1'b0;
    exp_q.push_back({1'b0, 16'd22});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t2_lat_fall_early", 32'(evt_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_lat_fall", 32'(evt_valid), 32'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    pin = 1'b1;
    exp_q.push_back({1'b1, 16'd10});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t2_lat_rise_early", 32'(evt_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_lat_rise", 32'(evt_valid), 32'd1);
    wait_drain();
    check("t2_edge_count", 32'(edge_count), 32'd2);
    check("t2_level", 32'(level), 32'd1);

    // 3: DEBOUNCE=3 instance, 2-cycle glitch then a 3-cycle low pulse
    reset_dut();
    repeat (10) @(posedge clk);
    @(negedge clk);
    pin3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pin3 = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_glitch_level", 32'(level3), 32'd1);
    check("t3_glitch_count", 32'(edge_count3), 32'd0);
    check("t3_glitch_fifo", 32'(fifo_level3), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    pin3 = 1'b0;
    exp3_q.push_back({1'b0, 16'd34});
    repeat (3) @(posedge clk);
    @(negedge clk);
    pin3 = 1'b1;
    exp3_q.push_back({1'b1, 16'd3});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_level_low", 32'(level3), 32'd0);
    wait_drain();
    check("t3_level_back", 32'(level3), 32'd1);
    check("t3_edge_count", 32'(edge_count3), 32'd2);

    // 4: ten toggles with no consumer, overflow, clear, ordered drain
    ready = 1'b0;
    reset_dut();
    toggles(10, 10, 8);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t4_fifo_level", 32'(fifo_level), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_edge_count", 32'(edge_count), 32'd10);
    check("t4_head_rise", 32'(evt_rise), 32'd0);
    check("t4_head_delta", 32'(evt_delta), 32'd12);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    ready = 1'b1;
    wait_drain();
    check("t4_empty", 32'(fifo_level), 32'd0);

    // 5: full FIFO, push and pop in the same cycle
    ready = 1'b0;
    reset_dut();
    toggles(8, 10, 8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_full", 32'(fifo_level), 32'd8);
    pin = ~pin;
    exp_q.push_back({pin, 16'd5});
    repeat (2) @(posedge clk);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    check("t5_level_kept", 32'(fifo_level), 32'd8);
    check("t5_no_overflow", 32'(overflow), 32'd0);
    ready = 1'b1;
    wait_drain();

    // 6: reset with 5 queued and both pins mid-qualification
    ready = 1'b0;
    reset_dut();
    toggles(5, 10, 5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_queued", 32'(fifo_level), 32'd5);
    pin = 1'b1;
    pin3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_rise", 32'(evt_rise), 32'd0);
    check("t6_delta", 32'(evt_delta), 32'd0);
    check("t6_level", 32'(level), 32'd1);
    check("t6_edge_count", 32'(edge_count), 32'd0);
    check("t6_fifo_level", 32'(fifo_level), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_level3", 32'(level3), 32'd1);
    pin3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_post_fifo", 32'(fifo_level), 32'd0);
    check("t6_post_count", 32'(edge_count), 32'd0);
    check("t6_post_count3", 32'(edge_count3), 32'd0);

    // 7: disabled edges track level only, re-enable adds nothing
    en = 1'b0;
    pin = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t7_level", 32'(level), 32'd0);
    check("t7_count_held", 32'(edge_count), 32'd0);
    check("t7_fifo_dis", 32'(fifo_level), 32'd0);
    en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t7_fifo_reen", 32'(fifo_level), 32'd0);
    check("t7_count_reen", 32'(edge_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
